alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 42 ++++
 rtl/alu_sequencer.sv | 114 +++++++++++
 tb/tb_alu_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, state encoding and opcode helpers for alu_sequencer
//
// Purpose: opcode constants (AND..NOT), FSM state encoding, parameter defaults
//          and opcode classification helpers used by the sequencer.
// Ports:   none (package).

package alu_seq_pkg;

   localparam int REG_SIZE_DEF  = 32;
   localparam int MC_CYCLES_DEF = 32;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1001;
   localparam logic [3:0] OP_NOR = 4'b1010;
   localparam logic [3:0] OP_NOT = 4'b1011;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_Y  = 3'd1,
      S_EXEC    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Opcodes above NOT (1100..1111) are rejected without touching the ALU.
   function automatic logic is_legal(input logic [3:0] op);
      return op <= OP_NOT;
   endfunction

   function automatic logic is_multi_cycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request sequencer driving an external ALU through IDLE/LOAD_Y/EXEC/CAPTURE/DONE
//
// Purpose: accepts one request at a time, loads operand A into Y, presents the
//          opcode and operand B to the ALU for the execute dwell, captures the
//          64-bit ALU result and pulses done (plus illegal for bad opcodes).
// Ports:
//   clk, clr            clock and asynchronous active-high reset
//   start, opcode       request strobe (honoured only while ready) and ALU op
//   operand_a/_b        operands; A goes to Y, B is driven on the ALU bus
//   ready               high only in IDLE
//   alu_ctrl/alu_y/alu_bus  control, Y register and bus operand to the ALU
//   alu_z               combinational ALU result
//   result_lo/_hi       captured low/high halves of alu_z
//   done, illegal       one-cycle completion pulse / illegal-opcode flag

module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int REG_SIZE  = REG_SIZE_DEF,
   parameter int MC_CYCLES = MC_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                start,
   input  logic [3:0]          opcode,
   input  logic [REG_SIZE-1:0] operand_a,
   input  logic [REG_SIZE-1:0] operand_b,
   output logic                ready,
   output logic [3:0]          alu_ctrl,
   output logic [REG_SIZE-1:0] alu_y,
   output logic [REG_SIZE-1:0] alu_bus,
   input  logic [63:0]         alu_z,
   output logic [REG_SIZE-1:0] result_lo,
   output logic [REG_SIZE-1:0] result_hi,
   output logic                done,
   output logic                illegal
);

   // Counter is reloaded with dwell-1 so that EXEC lasts exactly MC_CYCLES.
   localparam logic [7:0] MC_LOAD = 8'(MC_CYCLES - 1);

   state_t              state;
   logic [7:0]          cnt;
   logic [REG_SIZE-1:0] a_lat;

   // alu_ctrl and alu_bus double as the latched opcode and operand B: they are
   // loaded on acceptance and cleared when leaving CAPTURE.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_IDLE;
         ready     <= 1'b1;
         done      <= 1'b0;
         illegal   <= 1'b0;
         alu_ctrl  <= 4'b0000;
         alu_bus   <= '0;
         alu_y     <= '0;
         a_lat     <= '0;
         cnt       <= 8'd0;
         result_lo <= '0;
         result_hi <= '0;
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  ready <= 1'b0;
                  if (is_legal(opcode)) begin
                     state    <= S_LOAD_Y;
                     alu_ctrl <= opcode;
                     alu_bus  <= operand_b;
                     a_lat    <= operand_a;
                  end else begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     illegal <= 1'b1;
                  end
               end
            end
            S_LOAD_Y: begin
               alu_y <= a_lat;
               cnt   <= is_multi_cycle(alu_ctrl) ? MC_LOAD : 8'd0;
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (cnt == 8'd0) begin
                  state <= S_CAPTURE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            S_CAPTURE: begin
               result_lo <= REG_SIZE'(alu_z[31:0]);
               result_hi <= REG_SIZE'(alu_z[63:32]);
               alu_ctrl  <= 4'b0000;
               alu_bus   <= '0;
               done      <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               ready <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               ready    <= 1'b1;
               alu_ctrl <= 4'b0000;
               alu_bus  <= '0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with behavioural ALU and timeline model

module tb_alu_sequencer;

   localparam int MC = 32;

   logic        clk;
   logic        clr;
   logic        start;
   logic [3:0]  opcode;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_y;
   logic [31:0] alu_bus;
   logic [63:0] alu_z;
   logic [31:0] result_lo;
   logic [31:0] result_hi;
   logic        done;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_sequencer #(.REG_SIZE(32), .MC_CYCLES(MC)) dut (
      .clk(clk), .clr(clr), .start(start), .opcode(opcode),
      .operand_a(operand_a), .operand_b(operand_b), .ready(ready),
      .alu_ctrl(alu_ctrl), .alu_y(alu_y), .alu_bus(alu_bus), .alu_z(alu_z),
      .result_lo(result_lo), .result_hi(result_hi), .done(done), .illegal(illegal)
   );

   function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [31:0] y, input logic [31:0] b);
      case (op)
         4'b0000: return {32'b0, y & b};
         4'b0001: return {32'b0, y | b};
         4'b0010: return 64'(y) + 64'(b);
         4'b0011: return 64'(y) - 64'(b);
         4'b0100: return {32'b0, y ^ b};
         4'b0101: return {32'b0, y << b[4:0]};
         4'b0110: return {32'b0, y >> b[4:0]};
         4'b0111: return ($signed(y) < $signed(b)) ? 64'd1 : 64'd0;
         4'b1000: return 64'(y) * 64'(b);
         4'b1001: return (b == 32'd0) ? {64{1'b1}} : {y % b, y / b};
         4'b1010: return {32'b0, ~(y | b)};
         4'b1011: return {32'b0, ~y};
         default: return 64'd0;
      endcase
   endfunction

   assign alu_z = alu_f(alu_ctrl, alu_y, alu_bus);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: one outstanding request described by its accept cycle.
   int          cyc = 0;
   bit          m_active = 0;
   int          m_n;
   logic [3:0]  m_op;
   logic [31:0] m_a, m_b;
   int          m_len;
   bit          m_ill;
   logic [31:0] m_y = 0, m_lo = 0, m_hi = 0;
   bit          was_active;
   int          mk, m_end;
   logic [63:0] mz;

   always @(posedge clk) begin
      if (clr) begin
         m_active = 0;
         m_y = 0; m_lo = 0; m_hi = 0;
      end else begin
         was_active = m_active;
         if (m_active) begin
            mk    = cyc - m_n;
            m_end = m_ill ? 1 : 3 + m_len;
            if (!m_ill && mk == 1) m_y = m_a;
            if (!m_ill && mk == 2 + m_len) begin
               mz   = alu_f(m_op, m_a, m_b);
               m_lo = mz[31:0];
               m_hi = mz[63:32];
            end
            if (mk == m_end) m_active = 0;
         end
         if (!was_active && start) begin
            m_active = 1;
            m_n   = cyc;
            m_op  = opcode;
            m_a   = operand_a;
            m_b   = operand_b;
            m_ill = (opcode > 4'd11);
            m_len = (opcode == 4'd8 || opcode == 4'd9) ? MC : 1;
         end
      end
      cyc++;
   end

   bit          cmp_on = 0;
   int          ck, c_end;
   logic [3:0]  e_ctrl;
   logic [31:0] e_bus;
   bit          e_done, e_ill, in_alu;

   always @(negedge clk) begin
      if (cmp_on) begin
         ck     = cyc - m_n;
         c_end  = m_ill ? 1 : 3 + m_len;
         in_alu = m_active && !m_ill && ck >= 1 && ck <= 2 + m_len;
         e_ctrl = in_alu ? m_op : 4'b0000;
         e_bus  = in_alu ? m_b : 32'd0;
         e_done = m_active && ck == c_end;
         e_ill  = m_active && m_ill && ck == 1;
         check("ready",     64'(ready),     64'(!m_active));
         check("done",      64'(done),      64'(e_done));
         check("illegal",   64'(illegal),   64'(e_ill));
         check("alu_ctrl",  64'(alu_ctrl),  64'(e_ctrl));
         check("alu_bus",   64'(alu_bus),   64'(e_bus));
         check("alu_y",     64'(alu_y),     64'(m_y));
         check("result_lo", 64'(result_lo), 64'(m_lo));
         check("result_hi", 64'(result_hi), 64'(m_hi));
      end
   end

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noisy, output int lat, output int ctrl_cycles, output bit saw_ill);
      int n0;
      @(negedge clk);
      #1;
      start = 1'b1; opcode = op; operand_a = a; operand_b = b;
      n0 = cyc;
      lat = -1; ctrl_cycles = 0; saw_ill = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (alu_ctrl == 4'b1000) ctrl_cycles++;
         if (done) begin
            lat = cyc - n0;
            saw_ill = illegal;
            #1 start = 1'b0;
            break;
         end
         #1;
         if (noisy) begin
            start = 1'($urandom); opcode = 4'($urandom);
            operand_a = $urandom; operand_b = $urandom;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   int lat, cc;
   bit ill;
   logic [3:0]  rop;
   logic [31:0] ra, rb;
   int exp_lat;

   initial begin
      clr = 1'b1; start = 1'b0; opcode = 4'd0; operand_a = 32'd0; operand_b = 32'd0;
      repeat (3) @(negedge clk);
      cmp_on = 1;
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_ctrl", 64'(alu_ctrl), 64'd0);
      check("reset_lo", 64'(result_lo), 64'd0);
      #1 clr = 1'b0;

      run_op(4'b0010, 32'd5, 32'd7, 0, lat, cc, ill);
      check("add_latency", 64'(lat), 64'd4);
      check("add_lo", 64'(result_lo), 64'd12);
      check("add_hi", 64'(result_hi), 64'd0);
      check("add_illegal", 64'(ill), 64'd0);

      run_op(4'b0011, 32'd3, 32'd5, 0, lat, cc, ill);
      check("sub_latency", 64'(lat), 64'd4);
      check("sub_lo", 64'(result_lo), 64'hFFFF_FFFE);
      check("sub_hi", 64'(result_hi), 64'hFFFF_FFFF);

      run_op(4'b1000, 32'd1234, 32'd5678, 1, lat, cc, ill);
      check("mul_latency", 64'(lat), 64'd35);
      check("mul_ctrl_cycles", 64'(cc), 64'd34);
      check("mul_lo", 64'(result_lo), 64'd7006652);

      run_op(4'b0010, 32'd5, 32'd7, 0, lat, cc, ill);
      run_op(4'b1101, 32'd99, 32'd99, 0, lat, cc, ill);
      check("illegal_latency", 64'(lat), 64'd1);
      check("illegal_flag", 64'(ill), 64'd1);
      check("illegal_keeps_lo", 64'(result_lo), 64'd12);

      // Abort a multiply three cycles after acceptance.
      @(negedge clk);
      #1 start = 1'b1; opcode = 4'b1000; operand_a = 32'd9; operand_b = 32'd9;
      @(negedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 clr = 1'b1;
      @(negedge clk);
      check("clr_ready", 64'(ready), 64'd1);
      check("clr_done", 64'(done), 64'd0);
      check("clr_ctrl", 64'(alu_ctrl), 64'd0);
      check("clr_bus", 64'(alu_bus), 64'd0);
      check("clr_y", 64'(alu_y), 64'd0);
      check("clr_lo", 64'(result_lo), 64'd0);
      #1 clr = 1'b0;
      run_op(4'b0000, 32'hF0, 32'h3C, 0, lat, cc, ill);
      check("and_latency", 64'(lat), 64'd4);
      check("and_lo", 64'(result_lo), 64'h30);

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         rop = 4'($urandom);
         ra  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         exp_lat = (rop > 4'd11) ? 1 : ((rop == 4'd8 || rop == 4'd9) ? MC + 3 : 4);
         run_op(rop, ra, rb, 1'($urandom), lat, cc, ill);
         check("rand_latency", 64'(lat), 64'(exp_lat));
         check("rand_illegal", 64'(ill), 64'(rop > 4'd11));
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
